// File: rtl/tt_count_chk_pkg.sv
// Shared types and constants for the start/stop counter checker.
package tt_count_chk_pkg;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'b00,
    ST_LOCK  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  localparam logic [2:0] LOCK_THRESH = 3'd4;
  localparam logic [7:0] ERR_MAX     = 8'hFF;
  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating event counter; clear has priority over increment.
module sat_cnt8
  import tt_count_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (clr) begin
      q <= 8'h00;
    end else if (inc && (q != ERR_MAX)) begin
      q <= q + 8'd1;
    end
  end

endmodule

// File: rtl/tt_um_count_checker.sv
// Checks an observed start/stop counter sample stream against its own previous sample,
// locking after a run of good steps and logging errors seen while locked.
module tt_um_count_checker
  import tt_count_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       hold_in;
  logic       clr_err;
  logic       sel_bad;
  logic       unused_ok;

  logic [7:0] prev_val_q;
  logic       prev_hold_q;
  logic       prev_valid_q;
  state_e     state_q, state_d;
  logic [2:0] good_run_q, good_run_d;
  logic       locked_q;
  logic       err_sticky_q;
  logic [7:0] last_bad_q;
  logic [7:0] err_cnt_q;

  logic [7:0] expected;
  logic       match;
  logic       mismatch;
  logic       lock_err;

  assign hold_in   = uio_in[0];
  assign clr_err   = uio_in[1];
  assign sel_bad   = uio_in[2];
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  // A held counter repeats its value; a running one advances by one and wraps naturally.
  assign expected = prev_hold_q ? prev_val_q : (prev_val_q + 8'd1);
  assign match    = prev_valid_q && (ui_in == expected);
  assign mismatch = prev_valid_q && (ui_in != expected);

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    lock_err   = 1'b0;
    case (state_q)
      ST_ACQ: begin
        if (match) begin
          if (good_run_q == (LOCK_THRESH - 3'd1)) begin
            state_d    = ST_LOCK;
            good_run_d = 3'd0;
          end else begin
            good_run_d = good_run_q + 3'd1;
          end
        end else if (mismatch) begin
          good_run_d = 3'd0;
        end
      end
      ST_LOCK: begin
        if (mismatch) begin
          state_d  = ST_FAULT;
          lock_err = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d    = ST_ACQ;
        good_run_d = 3'd0;
      end
      default: begin
        state_d    = ST_ACQ;
        good_run_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_val_q   <= 8'h00;
      prev_hold_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      state_q      <= ST_ACQ;
      good_run_q   <= 3'd0;
      locked_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      last_bad_q   <= 8'h00;
    end else begin
      prev_val_q   <= ui_in;
      prev_hold_q  <= hold_in;
      prev_valid_q <= 1'b1;
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      locked_q     <= (state_d == ST_LOCK);
      // Clear beats a same-cycle error so software never sees a half-cleared log.
      if (clr_err) begin
        err_sticky_q <= 1'b0;
        last_bad_q   <= 8'h00;
      end else if (lock_err) begin
        err_sticky_q <= 1'b1;
        last_bad_q   <= ui_in;
      end
    end
  end

  sat_cnt8 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lock_err),
    .clr   (clr_err),
    .q     (err_cnt_q)
  );

  assign uo_out  = sel_bad ? last_bad_q : err_cnt_q;
  assign uio_out = {state_q, err_sticky_q, locked_q, 4'b0000};
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a monitor pops and compares.
module tb_tt_um_count_checker;

  localparam int ACQ   = 0;
  localparam int LOCK  = 1;
  localparam int FAULT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_count_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: what the checker should believe after each clock edge.
  bit m_have   = 0;
  int m_prev   = 0;
  bit m_ph     = 0;
  int m_mode   = ACQ;
  int m_run    = 0;
  int m_errs   = 0;
  int m_last   = 0;
  bit m_sticky = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic int good_next();
    if (!m_have) return 0;
    return m_ph ? m_prev : (m_prev + 1) % 256;
  endfunction

  function automatic void model_step(int s, bit h, bit c, bit rst);
    bit compared, ok;
    if (rst) begin
      m_have = 0; m_prev = 0; m_ph = 0; m_mode = ACQ; m_run = 0;
      m_errs = 0; m_last = 0; m_sticky = 0;
      return;
    end
    compared = m_have;
    ok       = compared && (s == good_next());
    if (m_mode == ACQ) begin
      if (ok) begin
        m_run = m_run + 1;
        if (m_run >= 4) begin m_mode = LOCK; m_run = 0; end
      end else if (compared) m_run = 0;
    end else if (m_mode == LOCK) begin
      if (compared && !ok) begin
        m_mode   = FAULT;
        m_errs   = (m_errs + 1 > 255) ? 255 : m_errs + 1;
        m_sticky = 1;
        m_last   = s;
      end
    end else begin
      m_mode = ACQ;
      m_run  = 0;
    end
    if (c) begin m_errs = 0; m_sticky = 0; m_last = 0; end
    m_prev = s; m_ph = h; m_have = 1;
  endfunction

  task automatic step(input int s, input bit h, input bit c, input bit sel, input bit rst);
    exp_t e;
    @(negedge clk);
    rst_n  = !rst;
    ui_in  = s[7:0];
    uio_in = {5'b00000, sel, c, h};
    model_step(s, h, c, rst);
    e.uo  = sel ? m_last[7:0] : m_errs[7:0];
    e.uio = {m_mode[1:0], m_sticky, (m_mode == LOCK), 4'b0000};
    sb_q.push_back(e);
    if (rst) begin
      #1;
      chk("async_rst_uo", uo_out, 8'h00);
      chk("async_rst_uio", uio_out, 8'h00);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 20 && m_mode != LOCK; i++) step(good_next(), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bad_in_lock(input bit c, input bit sel);
    step((good_next() + 1 + $urandom_range(253)) % 256, 1'b0, c, sel, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_uo_out", uo_out, e.uo);
        chk("sb_uio_out", uio_out, e.uio);
        chk("uio_oe", uio_oe, 8'hF0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v, n_bad;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Lock after four good steps following the priming sample.
    for (v = 0; v < 4; v++) step(v, 0, 0, 0, 0);
    settle();
    chk("not_locked_after_3", {7'b0, uio_out[4]}, 8'h00);
    step(4, 0, 0, 0, 0);
    settle();
    chk("locked_after_04", {7'b0, uio_out[4]}, 8'h01);
    chk("err_zero_after_lock", uo_out, 8'h00);

    // Wrap FF -> 00 is a legal step.
    for (v = 5; v < 256; v++) step(v, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("wrap_locked", {7'b0, uio_out[4]}, 8'h01);
    chk("wrap_no_err", uo_out, 8'h00);

    // Hold behaviour.
    for (v = 2; v < 16; v++) step(v, 0, 0, 0, 0);
    step(8'h10, 1, 0, 0, 0);
    step(8'h10, 1, 0, 0, 0);
    step(8'h10, 0, 0, 0, 0);
    step(8'h11, 0, 0, 0, 0);
    settle();
    chk("hold_no_err", uo_out, 8'h00);
    chk("hold_locked", {7'b0, uio_out[4]}, 8'h01);
    step(8'h12, 1, 0, 0, 0);
    step(8'h11, 0, 0, 0, 0);
    settle();
    chk("hold_err_cnt", uo_out, 8'h01);
    chk("hold_fault_state", {6'b0, uio_out[7:6]}, 8'h02);
    step(8'h12, 0, 0, 1, 0);
    settle();
    chk("hold_last_bad", uo_out, 8'h11);
    chk("fault_to_acq", {6'b0, uio_out[7:6]}, 8'h00);

    // Saturation through repeated lock/fault cycles.
    n_bad = 0;
    for (int i = 0; i < 6000 && n_bad < 300; i++) begin
      if (m_mode == LOCK) begin
        bad_in_lock(0, 1'($urandom_range(1)));
        n_bad++;
      end else begin
        step(good_next(), 0, 0, 1'($urandom_range(1)), 0);
      end
    end
    chk("sat_budget", {7'b0, n_bad >= 300}, 8'h01);
    step(good_next(), 0, 0, 0, 0);
    settle();
    chk("err_saturated", uo_out, 8'hFF);
    step(good_next(), 0, 0, 1, 0);
    settle();
    chk("sat_last_bad", uo_out, m_last[7:0]);

    // Clear wins over a simultaneous locked mismatch.
    lock_up();
    bad_in_lock(1, 1);
    settle();
    chk("clr_last_bad", uo_out, 8'h00);
    chk("clr_state_fault", uio_out, 8'h80);
    step(good_next(), 0, 0, 0, 0);
    settle();
    chk("clr_err_cnt", uo_out, 8'h00);

    // Five errors, then a reset pulse while locked.
    for (int i = 0; i < 5; i++) begin
      lock_up();
      bad_in_lock(0, 0);
    end
    lock_up();
    settle();
    chk("five_errs", uo_out, 8'h05);
    chk("locked_before_rst", {7'b0, uio_out[4]}, 8'h01);
    step(good_next(), 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (v = 8'h40; v < 8'h44; v++) step(v, 0, 0, 0, 0);
    settle();
    chk("relock_not_4", {7'b0, uio_out[4]}, 8'h00);
    step(8'h44, 0, 0, 0, 0);
    settle();
    chk("relock_5", {7'b0, uio_out[4]}, 8'h01);

    // Random phase.
    for (int i = 0; i < 2000; i++) begin
      int s;
      bit rst, c;
      rst = ($urandom_range(299) == 0);
      c   = ($urandom_range(49) == 0);
      if ($urandom_range(7) == 0) s = (good_next() + 1 + $urandom_range(253)) % 256;
      else s = good_next();
      step(s, 1'($urandom_range(1)), c, 1'($urandom_range(1)), rst);
    end

    settle();
    settle();
    chk("sb_drained", sb_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_um_count_checker.md
TT_UM_COUNT_CHECKER -- requirements
Module: tt_um_count_checker

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n as the codebase does.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port ena, input, 1, powered indicator; it SHALL be ignored.
REQ-005 Port ui_in, input, 8, observed count sample from the upstream start/stop counter.
REQ-006 Port uio_in, input, 8: [0] hold (the same start/stop level driven to the counter, 1 = hold); [1] clr_err; [2] sel_bad; [7:3] unused.
REQ-007 Port uo_out, output, 8: err_cnt when sel_bad=0, last_bad when sel_bad=1.
REQ-008 Port uio_out, output, 8: [7:6] state, [5] err_sticky, [4] locked, [3:0] constant 0.
REQ-009 Port uio_oe, output, 8, constant 8'hF0.

Function
REQ-010 Each cycle the block SHALL register sample=ui_in and hold=uio_in[0] into prev_val and prev_hold, and set prev_valid=1.
REQ-011 Expected value SHALL be prev_val when prev_hold=1, else prev_val+1 modulo 256; 8'hFF+1 SHALL expect 8'h00 with no error.
REQ-012 match SHALL be (ui_in == expected) and prev_valid=1; with prev_valid=0 no comparison SHALL occur and neither match nor mismatch SHALL be counted.
REQ-013 States: ACQ=2'b00, LOCK=2'b01, FAULT=2'b10; 2'b11 SHALL be unreachable and SHALL go to ACQ.
REQ-014 ACQ: good_run (3-bit) SHALL increment on match and clear on mismatch; on the 4th consecutive match the next state SHALL be LOCK and good_run SHALL clear.
REQ-015 LOCK: match SHALL stay in LOCK; mismatch SHALL go to FAULT, increment err_cnt, set err_sticky, and capture ui_in into last_bad, all on the same edge.
REQ-016 FAULT SHALL last exactly one cycle, then go to ACQ with good_run=0, regardless of the sample in that cycle.
REQ-017 Mismatches in ACQ or FAULT SHALL NOT change err_cnt, err_sticky or last_bad.
REQ-018 err_cnt SHALL be 8-bit and saturate at 8'hFF.
REQ-019 A mismatch in LOCK SHALL always update last_bad, including when err_cnt is saturated.
REQ-020 clr_err=1 SHALL synchronously clear err_cnt, err_sticky and last_bad; clr_err SHALL win over a simultaneous error; state and good_run SHALL be unaffected.
REQ-021 locked SHALL equal (state==LOCK); all outputs SHALL be driven directly from registers, with uo_out a mux on sel_bad only.

Reset
REQ-022 While rst_n=0: state=ACQ, good_run=0, prev_valid=0, prev_val=0, prev_hold=0, err_cnt=0, last_bad=0, err_sticky=0; resulting uo_out=0, uio_out=0.
REQ-023 An assertion of rst_n in any state, mid-run, SHALL return all state to the REQ-022 values immediately; the first sample after release SHALL only prime prev_val.

Structure
REQ-024 A shared package tt_count_chk_pkg SHALL hold the state typedef, LOCK_THRESH=4, ERR_MAX=8'hFF and UIO_OE_MASK=8'hF0.
REQ-025 The saturating error counter SHALL be one sub-module, sat_cnt8 (inc, clr, q), with clr having priority over inc.

Verification
REQ-026 Reset, hold=0, feed 00,01,02,03,04 -> locked=1 after the 4th match (sample 04), err_cnt=0.
REQ-027 Locked, feed FE,FF,00,01 -> no error across the wrap; locked stays 1.
REQ-028 Locked at 10 with hold=1, feed 10,10 then hold=0, 11 -> no error; feeding 11 while hold=1 -> err_cnt=1, last_bad=8'h11, state FAULT for one cycle, then ACQ.
REQ-029 Force 300 mismatches interleaved with re-locks -> err_cnt saturates at 8'hFF; sel_bad=1 shows the last bad sample.
REQ-030 Mismatch in LOCK on the same cycle as clr_err=1 -> err_cnt=0, err_sticky=0, last_bad=0, state=FAULT.
REQ-031 Pulse rst_n low while in LOCK with err_cnt=5 -> all outputs 0 asynchronously, state ACQ; relock needs 5 samples.
